// File: rtl/arilla_timer_if.sv
// Arilla system bus: word-addressed, 32-bit data, 4 byte enables.
// data_ptc is a shared net; responders release it to high-Z when not returning data.
interface arilla_bus_if #(
  parameter int ADDR_W = 32
) ();
  logic [ADDR_W-1:0] address;
  logic [3:0]        byte_enable;
  logic [31:0]       data_ctp;
  wire  [31:0]       data_ptc;
  logic              read;
  logic              write;
  logic              available;

  modport responder (
    input  address, byte_enable, data_ctp, read, write, available,
    output data_ptc
  );

  modport initiator (
    output address, byte_enable, data_ctp, read, write, available,
    input  data_ptc
  );
endinterface

// File: rtl/arilla_timer.sv
// Memory-mapped 64-bit machine timer (mtime/mtimecmp) with prescaler and registered
// interrupt; responds to word reads/writes on the arilla bus with one-cycle read latency.
module arilla_timer #(
  parameter int unsigned BaseAddress = 0
) (
  input  logic            clk,
  input  logic            rst,
  arilla_bus_if.responder bus_interface,
  output logic            timer_irq
);

  localparam int AW = $bits(bus_interface.address);
  localparam logic [AW-1:0] BaseW = AW'(BaseAddress);

  logic        hit;
  logic [2:0]  off;
  logic        wr_en;
  logic        rd_en;
  logic        tick;
  logic [31:0] rd_word;
  logic [31:0] ctrl_word;
  logic [31:0] ctrl_new;
  logic        unused_bits;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic        en_q, en_d;
  logic [15:0] presc_q, presc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] shadow_q, shadow_d;
  logic        pend_q, pend_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;

  function automatic logic [31:0] merge_be(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  assign hit       = (bus_interface.address[AW-1:3] == BaseW[AW-1:3]);
  assign off       = bus_interface.address[2:0];
  assign wr_en     = bus_interface.write && hit;
  // A read colliding with a write is dropped; the write still lands.
  assign rd_en     = bus_interface.read && hit && !bus_interface.write;
  assign ctrl_word = {presc_q, 15'b0, en_q};
  assign ctrl_new  = merge_be(ctrl_word, bus_interface.data_ctp, bus_interface.byte_enable);
  assign tick      = en_q && (cnt_q == presc_q);

  assign unused_bits = ^{ctrl_new[15:1], bus_interface.available};

  always_comb begin
    rd_word = 32'h0;
    case (off)
      3'd0:    rd_word = mtime_q[31:0];
      3'd1:    rd_word = shadow_q;
      3'd2:    rd_word = cmp_q[31:0];
      3'd3:    rd_word = cmp_q[63:32];
      3'd4:    rd_word = ctrl_word;
      default: rd_word = 32'h0;
    endcase
  end

  always_comb begin
    mtime_d  = mtime_q;
    cmp_d    = cmp_q;
    en_d     = en_q;
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    rdata_d  = rdata_q;
    pend_d   = rd_en;
    irq_d    = en_q && (mtime_q >= cmp_q);

    if (en_q) cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
    if (tick) mtime_d = mtime_q + 64'd1;

    if (rd_en) begin
      rdata_d = rd_word;
      if (off == 3'd0) shadow_d = mtime_q[63:32];
    end

    // Writes to either mtime word override the tick increment for this edge.
    if (wr_en) begin
      case (off)
        3'd0: mtime_d = {mtime_q[63:32],
                         merge_be(mtime_q[31:0], bus_interface.data_ctp, bus_interface.byte_enable)};
        3'd1: mtime_d = {merge_be(mtime_q[63:32], bus_interface.data_ctp, bus_interface.byte_enable),
                         mtime_q[31:0]};
        3'd2: cmp_d[31:0]  = merge_be(cmp_q[31:0], bus_interface.data_ctp, bus_interface.byte_enable);
        3'd3: cmp_d[63:32] = merge_be(cmp_q[63:32], bus_interface.data_ctp, bus_interface.byte_enable);
        3'd4: begin
          en_d    = ctrl_new[0];
          presc_d = ctrl_new[31:16];
          cnt_d   = 16'd0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q  <= 64'h0;
      cmp_q    <= 64'hFFFF_FFFF_FFFF_FFFF;
      en_q     <= 1'b0;
      presc_q  <= 16'h0;
      cnt_q    <= 16'h0;
      shadow_q <= 32'h0;
      pend_q   <= 1'b0;
      rdata_q  <= 32'h0;
      irq_q    <= 1'b0;
    end else begin
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      en_q     <= en_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  assign bus_interface.data_ptc = pend_q ? rdata_q : 32'bz;
  assign timer_irq              = irq_q;

endmodule

// File: tb/tb_arilla_timer.sv
// Randomized and directed bench for arilla_timer against a behavioural register model.
module tb_arilla_timer;

  localparam logic [31:0] BASE = 32'h0000_0040;

  logic clk = 1'b0;
  logic rst;
  logic irq;

  arilla_bus_if #(.ADDR_W(32)) bus ();

  arilla_timer #(.BaseAddress(BASE)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus_interface (bus),
    .timer_irq     (irq)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [63:0] m_time;
  logic [63:0] m_cmp;
  logic        m_en;
  logic [15:0] m_presc;
  int          m_phase;
  logic [31:0] m_shadow;
  logic        m_pend;
  logic [31:0] m_rdata;
  logic        m_irq;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic released();
    return (bus.data_ptc === 32'hzzzz_zzzz) || (bus.data_ptc === 32'h0);
  endfunction

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] regval(input logic [2:0] o);
    case (o)
      3'd0: return m_time[31:0];
      3'd1: return m_shadow;
      3'd2: return m_cmp[31:0];
      3'd3: return m_cmp[63:32];
      3'd4: return {m_presc, 15'b0, m_en};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_time = 64'h0; m_cmp = '1; m_en = 1'b0; m_presc = 16'h0; m_phase = 0;
    m_shadow = 32'h0; m_pend = 1'b0; m_rdata = 32'h0; m_irq = 1'b0;
  endtask

  // Applies one clock edge to the model using the pre-edge state.
  task automatic model_edge(input logic rd, input logic wr, input logic hit,
                            input logic [2:0] o, input logic [3:0] be, input logic [31:0] d);
    logic        tk;
    logic        irq_n;
    logic [63:0] t;
    logic [31:0] nw;
    irq_n = m_en && (m_time >= m_cmp);
    tk = 1'b0;
    if (m_en) begin
      m_phase++;
      tk = (m_phase % (int'(m_presc) + 1)) == 0;
    end
    if (rd && hit && !wr) begin
      m_pend  = 1'b1;
      m_rdata = regval(o);
      if (o == 3'd0) m_shadow = m_time[63:32];
    end else begin
      m_pend = 1'b0;
    end
    t = tk ? m_time + 64'd1 : m_time;
    if (wr && hit) begin
      case (o)
        3'd0: t = {m_time[63:32], mrg(m_time[31:0], d, be)};
        3'd1: t = {mrg(m_time[63:32], d, be), m_time[31:0]};
        3'd2: m_cmp[31:0]  = mrg(m_cmp[31:0], d, be);
        3'd3: m_cmp[63:32] = mrg(m_cmp[63:32], d, be);
        3'd4: begin
          nw = mrg({m_presc, 15'b0, m_en}, d, be);
          m_en = nw[0]; m_presc = nw[31:16]; m_phase = 0;
        end
        default: ;
      endcase
    end
    m_time = t;
    m_irq  = irq_n;
  endtask

  // Called at a negedge; drives one bus cycle, checks just after the edge, returns at next negedge.
  task automatic cyc(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [3:0] be, input logic [31:0] d);
    logic h;
    bus.read = rd; bus.write = wr; bus.address = addr; bus.byte_enable = be; bus.data_ctp = d;
    h = (addr[31:3] == BASE[31:3]);
    model_edge(rd, wr, h, addr[2:0], be, d);
    @(posedge clk); #1;
    if (m_pend) check("rdata", {32'h0, bus.data_ptc}, {32'h0, m_rdata});
    else        check("ptc_released", {63'h0, released()}, 64'd1);
    check("irq", {63'h0, irq}, {63'h0, m_irq});
    @(negedge clk);
    bus.read = 1'b0; bus.write = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, BASE, 4'h0, 32'h0);
  endtask

  task automatic wr_reg(input logic [2:0] o, input logic [31:0] d);
    cyc(1'b0, 1'b1, BASE + {29'h0, o}, 4'hF, d);
  endtask

  task automatic rd_expect(input string tag, input logic [2:0] o, input logic [31:0] exp);
    cyc(1'b1, 1'b0, BASE + {29'h0, o}, 4'hF, 32'h0);
    check(tag, {32'h0, bus.data_ptc}, {32'h0, exp});
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1;
    check("rst_irq", {63'h0, irq}, 64'd0);
    check("rst_ptc_released", {63'h0, released()}, 64'd1);
    rst = 1'b0;
    model_reset();
  endtask

  int n;

  initial begin
    rst = 1'b1;
    bus.read = 1'b0; bus.write = 1'b0; bus.address = BASE; bus.byte_enable = 4'h0;
    bus.data_ctp = 32'h0; bus.available = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("por_irq", {63'h0, irq}, 64'd0);
    check("por_ptc_released", {63'h0, released()}, 64'd1);
    rst = 1'b0;

    // Reset while running with irq high and a read outstanding
    wr_reg(3'd2, 32'd10);
    wr_reg(3'd3, 32'd0);
    wr_reg(3'd4, 32'h0000_0001);
    idle(50);
    check("irq_before_rst", {63'h0, irq}, 64'd1);
    cyc(1'b1, 1'b0, BASE, 4'hF, 32'h0);
    pulse_reset();
    rd_expect("rst_cmp_hi", 3'd3, 32'hFFFF_FFFF);
    rd_expect("rst_mtime_lo", 3'd0, 32'h0);

    // Count with prescale 0
    wr_reg(3'd4, 32'h0000_0001);
    idle(10);
    rd_expect("count10", 3'd0, 32'd10);
    idle(1);

    // Carry into the high word and shadow behaviour
    wr_reg(3'd4, 32'h0);
    wr_reg(3'd0, 32'hFFFF_FFFF);
    wr_reg(3'd1, 32'h0);
    wr_reg(3'd4, 32'h0000_0001);
    idle(1);
    rd_expect("carry_lo", 3'd0, 32'h0);
    rd_expect("carry_hi", 3'd1, 32'h1);
    wr_reg(3'd4, 32'h0);
    wr_reg(3'd1, 32'h5);
    rd_expect("stale_shadow", 3'd1, 32'h1);

    // Byte-enable write
    @(negedge clk);
    pulse_reset();
    cyc(1'b0, 1'b1, BASE + 32'd2, 4'b0010, 32'h0000_AB00);
    rd_expect("be_cmp_lo", 3'd2, 32'hFFFF_ABFF);

    // IRQ with prescale 3
    wr_reg(3'd2, 32'd5);
    wr_reg(3'd3, 32'd0);
    wr_reg(3'd4, 32'h0003_0001);
    idle(19);
    check("irq_pre", {63'h0, irq}, 64'd0);
    idle(1);
    check("irq_at_match_edge", {63'h0, irq}, 64'd0);
    idle(1);
    check("irq_rise", {63'h0, irq}, 64'd1);
    rd_expect("mtime_5", 3'd0, 32'd5);
    wr_reg(3'd2, 32'd100);
    check("irq_hold_write_edge", {63'h0, irq}, 64'd1);
    idle(1);
    check("irq_fall", {63'h0, irq}, 64'd0);

    // Write/tick collision with prescale 0
    wr_reg(3'd4, 32'h0000_0001);
    idle(3);
    wr_reg(3'd0, 32'h0000_1234);
    idle(4);
    rd_expect("collision", 3'd0, 32'h0000_1238);
    rd_expect("off5_zero", 3'd5, 32'h0);

    // Misses leave state and bus alone
    cyc(1'b0, 1'b1, BASE + 32'd8, 4'hF, 32'hDEAD_BEEF);
    cyc(1'b1, 1'b0, BASE + 32'd10, 4'hF, 32'h0);
    cyc(1'b0, 1'b1, BASE - 32'd6, 4'hF, 32'hDEAD_BEEF);
    rd_expect("cmp_after_miss", 3'd2, 32'd100);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [2:0]  o;
      logic [3:0]  be;
      logic [31:0] d;
      n  = $urandom_range(0, 15);
      o  = 3'($urandom_range(0, 7));
      be = 4'($urandom);
      d  = $urandom;
      if (n < 5)       idle(1);
      else if (n < 9)  cyc(1'b1, 1'b0, BASE + {29'h0, o}, be, 32'h0);
      else if (n == 9) cyc(1'($urandom), 1'($urandom), BASE + 32'd8 + {29'h0, o}, be, d);
      else if (n == 10) cyc(1'b1, 1'b1, BASE + {29'h0, o}, be, d);
      else if (n == 11) wr_reg(3'd4, ({30'h0, 2'($urandom_range(0, 3))} << 16) |
                                     {31'h0, ($urandom_range(0, 5) != 0)});
      else if (n == 12) wr_reg(3'd2, m_time[31:0] + $urandom_range(0, 30));
      else if (n == 13) wr_reg(3'd3, m_time[63:32] + {31'h0, 1'($urandom_range(0, 1))});
      else if (n == 14) cyc(1'b0, 1'b1, BASE + {31'h0, 1'($urandom)}, be,
                            ($urandom_range(0, 3) == 0) ? d : m_time[31:0]);
      else              cyc(1'b0, 1'b1, BASE + 32'd5 + {30'h0, 2'($urandom_range(0, 2))}, be, d);
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
